// File: rtl/div_unit_pkg.sv
// Shared definitions for the iterative integer divider.
// Includes the divide opcodes, the FSM state encoding and the default operand width.
package div_unit_pkg;

  localparam int DIV_WIDTH = 32;

  localparam logic [7:0] EXE_DIV_OP  = 8'b0001_1010;
  localparam logic [7:0] EXE_DIVU_OP = 8'b0001_1011;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'b00,
    DIV_BUSY = 2'b01,
    DIV_ZERO = 2'b10,
    DIV_DONE = 2'b11
  } div_state_t;

endpackage

// File: rtl/div_unit_step.sv
// One combinational restoring-division step: shift in a dividend bit, trial-subtract, keep or restore.
// Kept standalone so a radix-4 variant can chain two of them per cycle.
module div_step
  import div_unit_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic [WIDTH:0]   rem_in,
  input  logic             dvd_bit,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH:0]   rem_out,
  output logic             q_bit
);

  logic [WIDTH+1:0] shifted;
  logic [WIDTH+1:0] diff;

  always_comb begin
    shifted = {rem_in, dvd_bit};
    diff    = shifted - {2'b00, divisor};
    // A clear sign bit means the divisor fit into the shifted partial remainder.
    q_bit   = ~diff[WIDTH+1];
    rem_out = q_bit ? diff[WIDTH:0] : shifted[WIDTH:0];
  end

endmodule

// File: rtl/div_unit.sv
// Multi-cycle restoring divider for DIV/DIVU: one quotient bit per cycle.
// Returns {remainder, quotient} for HI/LO and stalls the pipeline while iterating.
module div_unit
  import div_unit_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               signed_div,
  input  logic               annul,
  input  logic [WIDTH-1:0]   num1,
  input  logic [WIDTH-1:0]   num2,
  output logic [2*WIDTH-1:0] result,
  output logic               ready,
  output logic               stall
);

  localparam int CNT_W = $clog2(WIDTH);

  div_state_t       state;
  div_state_t       state_next;
  logic [CNT_W-1:0] count;
  logic [WIDTH:0]   rem;
  logic [WIDTH-1:0] dvd;
  logic [WIDTH-1:0] divisor;
  logic             sign_q;
  logic             sign_r;

  logic             capture;
  logic             finish;
  logic             neg1;
  logic             neg2;
  logic [WIDTH-1:0] mag1;
  logic [WIDTH-1:0] mag2;
  logic [WIDTH:0]   step_rem;
  logic             step_q;
  logic [WIDTH-1:0] quo_final;
  logic [WIDTH-1:0] rem_final;

  // Magnitudes as unsigned values; -0x80000000 wraps back to 0x80000000, which is the right magnitude.
  assign neg1 = signed_div & num1[WIDTH-1];
  assign neg2 = signed_div & num2[WIDTH-1];
  assign mag1 = neg1 ? -num1 : num1;
  assign mag2 = neg2 ? -num2 : num2;

  div_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .rem_in  (rem),
    .dvd_bit (dvd[WIDTH-1]),
    .divisor (divisor),
    .rem_out (step_rem),
    .q_bit   (step_q)
  );

  // Quotient bits shift into the vacated low end of the dividend register.
  assign quo_final = {dvd[WIDTH-2:0], step_q};
  assign rem_final = step_rem[WIDTH-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= DIV_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    capture    = 1'b0;
    finish     = 1'b0;
    ready      = 1'b0;
    stall      = 1'b0;
    case (state)
      DIV_IDLE: begin
        if (start && !annul) begin
          capture    = 1'b1;
          stall      = 1'b1;
          state_next = (num2 == '0) ? DIV_ZERO : DIV_BUSY;
        end
      end
      DIV_BUSY: begin
        stall = 1'b1;
        if (annul) begin
          state_next = DIV_IDLE;
        end else if (count == CNT_W'(WIDTH - 1)) begin
          finish     = 1'b1;
          state_next = DIV_DONE;
        end
      end
      DIV_ZERO: begin
        stall = 1'b1;
        if (annul) begin
          state_next = DIV_IDLE;
        end else begin
          finish     = 1'b1;
          state_next = DIV_DONE;
        end
      end
      DIV_DONE: begin
        // Stall stays low here so the pipeline can consume the result.
        ready = 1'b1;
        if (annul) begin
          state_next = DIV_IDLE;
        end else if (start) begin
          capture    = 1'b1;
          state_next = (num2 == '0) ? DIV_ZERO : DIV_BUSY;
        end else begin
          state_next = DIV_IDLE;
        end
      end
      default: state_next = DIV_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count   <= '0;
      rem     <= '0;
      dvd     <= '0;
      divisor <= '0;
      sign_q  <= 1'b0;
      sign_r  <= 1'b0;
    end else if (capture) begin
      count   <= '0;
      rem     <= '0;
      dvd     <= mag1;
      divisor <= mag2;
      sign_q  <= neg1 ^ neg2;
      sign_r  <= neg1;
    end else if (state == DIV_BUSY) begin
      count <= count + CNT_W'(1);
      rem   <= step_rem;
      dvd   <= quo_final;
    end
  end

  // Result only moves on DONE entry; annulled or reset operations never touch it otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result <= '0;
    end else if (finish) begin
      if (state == DIV_ZERO) begin
        result <= '0;
      end else begin
        result <= {(sign_r ? -rem_final : rem_final), (sign_q ? -quo_final : quo_final)};
      end
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed scenarios plus a randomized scoreboard run.
// Expected results come from a 64-bit reference division and are queued at issue time.
module tb_div_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        signed_div;
  logic        annul;
  logic [31:0] num1;
  logic [31:0] num2;
  logic [63:0] result;
  logic        ready;
  logic        stall;

  int checks   = 0;
  int failures = 0;

  logic [63:0] exp_q[$];
  int          lat_q[$];

  div_unit dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .signed_div (signed_div),
    .annul      (annul),
    .num1       (num1),
    .num2       (num2),
    .result     (result),
    .ready      (ready),
    .stall      (stall)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b, input logic sgn);
    longint sa;
    longint sb;
    longint q;
    longint r;
    if (b == 32'd0) return 64'd0;
    if (sgn) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end else begin
      sa = longint'({32'd0, a});
      sb = longint'({32'd0, b});
    end
    q = sa / sb;
    r = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // Advance until ready or the cycle budget runs out; counts cycles and non-stalled waiting cycles.
  task automatic wait_ready(input int limit, output int cycles, output bit seen, output int stall_lows);
    cycles = 0;
    seen = 1'b0;
    stall_lows = 0;
    while (!seen && cycles < limit) begin
      step();
      start = 1'b0;
      cycles++;
      #1;
      if (ready) seen = 1'b1;
      else if (!stall) stall_lows++;
    end
  endtask

  task automatic do_div(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                        output int cyc, output bit seen, output int lows, output logic issue_stall);
    step();
    num1 = a;
    num2 = b;
    signed_div = sgn;
    start = 1'b1;
    exp_q.push_back(model(a, b, sgn));
    #1;
    issue_stall = stall;
    wait_ready(40, cyc, seen, lows);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start = 1'b0;
    signed_div = 1'b0;
    annul = 1'b0;
    num1 = '0;
    num2 = '0;
    step();
    step();
    checks++;
    if (result !== 64'd0) begin failures++; $display("FAIL reset_result: got %h expected 0", result); end
    checks++;
    if (ready !== 1'b0) begin failures++; $display("FAIL reset_ready: got %b expected 0", ready); end
    checks++;
    if (stall !== 1'b0) begin failures++; $display("FAIL reset_stall: got %b expected 0", stall); end
    rst = 1'b0;
    $display("test_reset done");
  endtask

  task automatic test_divu_basic();
    int cyc;
    int lows;
    bit seen;
    logic is;
    logic [63:0] exp;
    do_div(32'd100, 32'd7, 1'b0, cyc, seen, lows, is);
    exp = exp_q.pop_front();
    checks++;
    if (is !== 1'b1) begin failures++; $display("FAIL divu_issue_stall: got %b expected 1", is); end
    checks++;
    if (!seen || cyc != 33) begin failures++; $display("FAIL divu_latency: got %0d (seen=%0b) expected 33", cyc, seen); end
    checks++;
    if (lows != 0) begin failures++; $display("FAIL divu_busy_stall: %0d unstalled cycles expected 0", lows); end
    checks++;
    if (stall !== 1'b0) begin failures++; $display("FAIL divu_done_stall: got %b expected 0", stall); end
    checks++;
    if (result !== exp) begin failures++; $display("FAIL divu_result: got %h expected %h", result, exp); end
    checks++;
    if (result !== {32'd2, 32'd14}) begin failures++; $display("FAIL divu_result_const: got %h expected %h", result, {32'd2, 32'd14}); end
    step();
    checks++;
    if (ready !== 1'b0) begin failures++; $display("FAIL divu_ready_width: got %b expected 0", ready); end
    $display("test_divu_basic 100/7 -> %h", result);
  endtask

  task automatic test_signed();
    int cyc;
    int lows;
    bit seen;
    logic is;
    logic [63:0] exp;
    do_div(32'hFFFF_FFF9, 32'd2, 1'b1, cyc, seen, lows, is);
    exp = exp_q.pop_front();
    checks++;
    if (!seen || result !== exp || result !== {32'hFFFF_FFFF, 32'hFFFF_FFFD}) begin
      failures++;
      $display("FAIL div_neg7_2: got %h expected %h", result, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
    end
    $display("test_signed DIV -7/2 -> %h", result);
    do_div(32'hFFFF_FFF9, 32'd2, 1'b0, cyc, seen, lows, is);
    exp = exp_q.pop_front();
    checks++;
    if (!seen || result !== exp || result !== {32'd1, 32'h7FFF_FFFC}) begin
      failures++;
      $display("FAIL divu_fff9_2: got %h expected %h", result, {32'd1, 32'h7FFF_FFFC});
    end
    $display("test_signed DIVU fffffff9/2 -> %h", result);
  endtask

  task automatic test_overflow();
    int cyc;
    int lows;
    bit seen;
    logic is;
    logic [63:0] exp;
    do_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, cyc, seen, lows, is);
    exp = exp_q.pop_front();
    checks++;
    if (!seen || cyc != 33) begin failures++; $display("FAIL ovf_latency: got %0d (seen=%0b) expected 33", cyc, seen); end
    checks++;
    if (result !== exp || result !== {32'h0, 32'h8000_0000}) begin
      failures++;
      $display("FAIL ovf_result: got %h expected %h", result, {32'h0, 32'h8000_0000});
    end
    $display("test_overflow 80000000/ffffffff -> %h", result);
  endtask

  task automatic test_divzero();
    int cyc;
    int lows;
    bit seen;
    logic is;
    logic [63:0] exp;
    do_div(32'd5, 32'd0, 1'b0, cyc, seen, lows, is);
    exp = exp_q.pop_front();
    checks++;
    if (is !== 1'b1) begin failures++; $display("FAIL dz_issue_stall: got %b expected 1", is); end
    checks++;
    if (!seen || cyc != 2) begin failures++; $display("FAIL dz_latency: got %0d (seen=%0b) expected 2", cyc, seen); end
    checks++;
    if (result !== exp) begin failures++; $display("FAIL dz_result: got %h expected %h", result, exp); end
    checks++;
    if (stall !== 1'b0) begin failures++; $display("FAIL dz_done_stall: got %b expected 0", stall); end
    step();
    checks++;
    if (stall !== 1'b0 || ready !== 1'b0) begin
      failures++;
      $display("FAIL dz_after: stall=%b ready=%b expected 0 0", stall, ready);
    end
    $display("test_divzero 5/0 -> %h", result);
  endtask

  task automatic test_annul();
    int cyc;
    int lows;
    int ready_hits;
    bit seen;
    logic is;
    logic [63:0] exp;
    logic [63:0] prior;
    do_div(32'd1000, 32'd3, 1'b0, cyc, seen, lows, is);
    exp = exp_q.pop_front();
    checks++;
    if (!seen || result !== exp) begin failures++; $display("FAIL annul_prior: got %h expected %h", result, exp); end
    prior = exp;
    step();
    num1 = 32'h1234_5678;
    num2 = 32'h11;
    signed_div = 1'b0;
    start = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      start = 1'b0;
    end
    annul = 1'b1;
    #1;
    checks++;
    if (stall !== 1'b1) begin failures++; $display("FAIL annul_busy_stall: got %b expected 1", stall); end
    step();
    annul = 1'b0;
    #1;
    checks++;
    if (stall !== 1'b0 || ready !== 1'b0) begin
      failures++;
      $display("FAIL annul_idle: stall=%b ready=%b expected 0 0", stall, ready);
    end
    ready_hits = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (ready) ready_hits++;
    end
    checks++;
    if (ready_hits != 0) begin failures++; $display("FAIL annul_no_ready: got %0d ready cycles expected 0", ready_hits); end
    checks++;
    if (result !== prior) begin failures++; $display("FAIL annul_result_kept: got %h expected %h", result, prior); end
    // Annul and start together in IDLE: annul wins, nothing issues.
    start = 1'b1;
    annul = 1'b1;
    #1;
    checks++;
    if (stall !== 1'b0) begin failures++; $display("FAIL annul_beats_start: stall=%b expected 0", stall); end
    step();
    start = 1'b0;
    annul = 1'b0;
    #1;
    checks++;
    if (stall !== 1'b0) begin failures++; $display("FAIL annul_start_idle: stall=%b expected 0", stall); end
    $display("test_annul result kept %h", result);
  endtask

  task automatic test_back_to_back();
    int cyc;
    int lows;
    bit seen;
    logic is;
    logic [63:0] exp;
    do_div(32'd77777, 32'd123, 1'b0, cyc, seen, lows, is);
    exp = exp_q.pop_front();
    checks++;
    if (!seen || result !== exp) begin failures++; $display("FAIL b2b_first: got %h expected %h", result, exp); end
    num1 = 32'hFFFF_0000;
    num2 = 32'h0000_0FFF;
    signed_div = 1'b1;
    start = 1'b1;
    exp_q.push_back(model(32'hFFFF_0000, 32'h0000_0FFF, 1'b1));
    #1;
    checks++;
    if (stall !== 1'b0) begin failures++; $display("FAIL b2b_done_stall: got %b expected 0", stall); end
    wait_ready(40, cyc, seen, lows);
    exp = exp_q.pop_front();
    checks++;
    if (!seen || cyc != 33) begin failures++; $display("FAIL b2b_latency: got %0d (seen=%0b) expected 33", cyc, seen); end
    checks++;
    if (result !== exp) begin failures++; $display("FAIL b2b_second: got %h expected %h", result, exp); end
    $display("test_back_to_back second -> %h", result);
  endtask

  task automatic test_rst_mid();
    int cyc;
    int lows;
    bit seen;
    logic is;
    logic [63:0] exp;
    step();
    num1 = 32'hDEAD_BEEF;
    num2 = 32'h1234;
    signed_div = 1'b0;
    start = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      start = 1'b0;
    end
    #1;
    rst = 1'b1;
    #1;
    checks++;
    if (result !== 64'd0 || ready !== 1'b0 || stall !== 1'b0) begin
      failures++;
      $display("FAIL rst_mid: result=%h ready=%b stall=%b expected 0 0 0", result, ready, stall);
    end
    rst = 1'b0;
    do_div(32'd100, 32'd7, 1'b0, cyc, seen, lows, is);
    exp = exp_q.pop_front();
    checks++;
    if (!seen || cyc != 33 || result !== exp) begin
      failures++;
      $display("FAIL rst_recover: cyc=%0d result=%h expected 33 %h", cyc, result, exp);
    end
    $display("test_rst_mid recovered -> %h", result);
  endtask

  task automatic gen_op(output logic [31:0] a, output logic [31:0] b, output logic s);
    int sel;
    sel = $urandom_range(0, 15);
    a = $urandom;
    b = $urandom;
    s = 1'($urandom_range(0, 1));
    case (sel)
      0: b = 32'd0;
      1: b = ($urandom_range(0, 1) == 0) ? 32'd1 : 32'hFFFF_FFFF;
      2: a = 32'h8000_0000;
      3: b = 32'($urandom_range(1, 255));
      4: b = 32'h8000_0000;
      default: ;
    endcase
  endtask

  task automatic test_random();
    int n;
    int cyc;
    int lows;
    int exp_lat;
    bit seen;
    logic [31:0] a;
    logic [31:0] b;
    logic s;
    logic [63:0] exp;
    n = 1000;
    step();
    gen_op(a, b, s);
    num1 = a;
    num2 = b;
    signed_div = s;
    start = 1'b1;
    exp_q.push_back(model(a, b, s));
    lat_q.push_back((b == 32'd0) ? 2 : 33);
    for (int i = 0; i < n; i++) begin
      wait_ready(40, cyc, seen, lows);
      exp = exp_q.pop_front();
      exp_lat = lat_q.pop_front();
      checks++;
      if (!seen || cyc != exp_lat) begin
        failures++;
        $display("FAIL rand_latency[%0d]: got %0d (seen=%0b) expected %0d", i, cyc, seen, exp_lat);
      end
      checks++;
      if (result !== exp) begin failures++; $display("FAIL rand_result[%0d]: got %h expected %h", i, result, exp); end
      if (!seen) break;
      if (i < n - 1) begin
        gen_op(a, b, s);
        num1 = a;
        num2 = b;
        signed_div = s;
        start = 1'b1;
        exp_q.push_back(model(a, b, s));
        lat_q.push_back((b == 32'd0) ? 2 : 33);
      end
    end
    step();
    start = 1'b0;
    #1;
    checks++;
    if (ready !== 1'b0) begin failures++; $display("FAIL rand_ready_width: got %b expected 0", ready); end
    $display("test_random %0d operations", n);
  endtask

  initial begin
    test_reset();
    test_divu_basic();
    test_signed();
    test_overflow();
    test_divzero();
    test_annul();
    test_back_to_back();
    test_rst_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
